// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes and
// the init/run state encoding.
package dmem_responder_pkg;

  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  typedef enum logic {
    DMEM_INIT = 1'b0,
    DMEM_RUN  = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for a 32-bit word: store byte enables and
// replicated write data, alignment/size fault, and right-aligned read data.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  ofs_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wr_data_o,
  output logic        align_err_o,
  output logic [31:0] rd_data_o
);

  logic [31:0] shifted;

  always_comb begin
    byte_en_o   = 4'b0000;
    wr_data_o   = 32'h0;
    align_err_o = 1'b0;
    rd_data_o   = 32'h0;
    shifted     = rd_word_i >> {ofs_i, 3'b000};
    case (size_i)
      SIZE_BYTE: begin
        byte_en_o = 4'b0001 << ofs_i;
        wr_data_o = {4{store_data_i[7:0]}};
        rd_data_o = {24'h0, shifted[7:0]};
      end
      SIZE_HALF: begin
        align_err_o = ofs_i[0];
        byte_en_o   = 4'b0011 << ofs_i;
        wr_data_o   = {2{store_data_i[15:0]}};
        rd_data_o   = {16'h0, shifted[15:0]};
      end
      SIZE_WORD: begin
        align_err_o = |ofs_i;
        byte_en_o   = 4'b1111;
        wr_data_o   = store_data_i;
        rd_data_o   = shifted;
      end
      default: begin
        align_err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised array cleared after reset, byte/half/word
// access with one-cycle response latency and fault reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              MEM_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADR  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            rsp_v_o,
  output logic            err_o,
  output logic            ready_o,
  output dmem_state_t     dbg_state_o
);

  localparam int AW = $clog2(MEM_WORDS);
  // Range bounds carry one extra bit so the top of the window cannot wrap.
  localparam logic [XLEN:0] LO_ADR = {1'b0, BASE_ADR};
  localparam logic [XLEN:0] HI_ADR = LO_ADR + (XLEN+1)'(4 * MEM_WORDS);

  dmem_state_t     state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            rsp_v_q, rsp_v_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [XLEN-1:0] mem_q [MEM_WORDS];

  logic [XLEN-1:0] offset;
  logic [AW-1:0]   req_idx;
  logic            in_range;
  logic            fault;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata;
  logic            lane_err;
  logic [31:0]     lane_rdata;

  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;

  assign offset   = adr_i - BASE_ADR;
  assign req_idx  = offset[AW+1:2];
  assign in_range = ({1'b0, adr_i} >= LO_ADR) && ({1'b0, adr_i} < HI_ADR);
  assign fault    = (state_q == DMEM_INIT) || !in_range || lane_err;

  dmem_lane_align u_lane (
    .size_i       (access_size_i),
    .ofs_i        (adr_i[1:0]),
    .store_data_i (store_data_i),
    .rd_word_i    (mem_q[req_idx]),
    .byte_en_o    (lane_be),
    .wr_data_o    (lane_wdata),
    .align_err_o  (lane_err),
    .rd_data_o    (lane_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rsp_v_d     = adr_v_i;
    err_d       = 1'b0;
    load_data_d = '0;
    mem_we      = 1'b0;
    mem_idx     = req_idx;
    mem_be      = lane_be;
    mem_wdata   = lane_wdata;

    case (state_q)
      DMEM_INIT: begin
        // The clear sweep owns the write port; requests all fault here.
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_be    = 4'b1111;
        mem_wdata = 32'h0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AW'(MEM_WORDS - 1)) begin
          state_d = DMEM_RUN;
          ready_d = 1'b1;
        end
      end
      DMEM_RUN: begin
        mem_we = adr_v_i && is_store_i && !fault;
      end
      default: begin
        state_d = DMEM_INIT;
      end
    endcase

    if (adr_v_i) begin
      err_d = fault;
      if (!fault && !is_store_i) begin
        load_data_d = lane_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DMEM_INIT;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_v_q     <= rsp_v_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign load_data_o = load_data_q;
  assign rsp_v_o     = rsp_v_q;
  assign err_o       = err_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a 16-word array at base 0.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        adr_v_i;
  logic [31:0] adr_i;
  logic        is_store_i;
  logic [31:0] store_data_i;
  logic [2:0]  access_size_i;
  logic [31:0] load_data_o;
  logic        rsp_v_o;
  logic        err_o;
  logic        ready_o;
  dmem_state_t dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic        st;
    logic [31:0] adr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        exp_err;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.XLEN(32), .MEM_WORDS(MW), .BASE_ADR(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .adr_v_i       (adr_v_i),
    .adr_i         (adr_i),
    .is_store_i    (is_store_i),
    .store_data_i  (store_data_i),
    .access_size_i (access_size_i),
    .load_data_o   (load_data_o),
    .rsp_v_o       (rsp_v_o),
    .err_o         (err_o),
    .ready_o       (ready_o),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic st, input logic [31:0] adr,
                       input logic [31:0] data, input logic [2:0] size);
    adr_v_i       = v;
    is_store_i    = st;
    adr_i         = adr;
    store_data_i  = data;
    access_size_i = size;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, SIZE_WORD);
  endtask

  task automatic check_rsp(input string name, input logic v, input logic e, input logic [31:0] d);
    chk({name, "_v"}, {31'h0, rsp_v_o}, {31'h0, v});
    chk({name, "_err"}, {31'h0, err_o}, {31'h0, e});
    chk({name, "_data"}, load_data_o, d);
  endtask

  // One request, response checked one cycle later against the scoreboard queue.
  task automatic req(input vec_t t);
    @(negedge clk);
    drive(1'b1, t.st, t.adr, t.data, t.size);
    exp_q.push_back(t.exp_d);
    @(negedge clk);
    check_rsp(t.name, 1'b1, t.exp_err, exp_q.pop_front());
    idle();
  endtask

  function automatic vec_t mk(input string name, input logic st, input logic [31:0] adr,
                              input logic [31:0] data, input logic [2:0] size,
                              input logic e, input logic [31:0] d);
    vec_t t;
    t.name = name; t.st = st; t.adr = adr; t.data = data; t.size = size;
    t.exp_err = e; t.exp_d = d;
    return t;
  endfunction

  // Holds reset for three cycles with a live request, then releases it.
  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h0, SIZE_WORD);
    repeat (3) begin
      @(negedge clk);
      check_rsp({name, "_in_reset"}, 1'b0, 1'b0, 32'h0);
      chk({name, "_in_reset_ready"}, {31'h0, ready_o}, 32'h0);
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic count_init(input string name);
    for (int i = 0; i < MW; i++) begin
      chk({name, "_init_ready"}, {31'h0, ready_o}, 32'h0);
      @(negedge clk);
    end
    chk({name, "_ready_rise"}, {31'h0, ready_o}, 32'h1);
    chk({name, "_state_run"}, {31'h0, dbg_state}, {31'h0, DMEM_RUN});
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready_o && k < 4 * MW) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_ready_timeout"}, {31'h0, ready_o}, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // 1: reset and exact init length
    do_reset("t1");
    count_init("t1");
    req(mk("t1_load_w2", 1'b0, 32'h8, 32'h0, SIZE_WORD, 1'b0, 32'h0));
    req(mk("t1_load_w15", 1'b0, 32'h3C, 32'h0, SIZE_WORD, 1'b0, 32'h0));

    // 2: requests during init fault and leave the array alone
    do_reset("t2");
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h8, 32'h0, SIZE_WORD);
    @(negedge clk);
    check_rsp("t2_init_load", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, SIZE_WORD);
    @(negedge clk);
    check_rsp("t2_init_store", 1'b1, 1'b1, 32'h0);
    idle();
    wait_ready("t2");
    req(mk("t2_after_w2", 1'b0, 32'h8, 32'h0, SIZE_WORD, 1'b0, 32'h0));
    req(mk("t2_after_w0", 1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0, 32'h0));

    // 3/4: lane behaviour and fault cases
    vecs.push_back(mk("st_w_10",   1'b1, 32'h10, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 32'h0));
    vecs.push_back(mk("st_b_11",   1'b1, 32'h11, 32'hFFFF_FF55, SIZE_BYTE, 1'b0, 32'h0));
    vecs.push_back(mk("st_h_12",   1'b1, 32'h12, 32'h1234_A5A5, SIZE_HALF, 1'b0, 32'h0));
    vecs.push_back(mk("ld_w_10",   1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 32'hA5A5_55EF));
    vecs.push_back(mk("ld_b_13",   1'b0, 32'h13, 32'h0, SIZE_BYTE, 1'b0, 32'h0000_00A5));
    vecs.push_back(mk("ld_h_10",   1'b0, 32'h10, 32'h0, SIZE_HALF, 1'b0, 32'h0000_55EF));
    vecs.push_back(mk("ld_h_11",   1'b0, 32'h11, 32'h0, SIZE_HALF, 1'b1, 32'h0));
    vecs.push_back(mk("st_w_12",   1'b1, 32'h12, 32'h0, SIZE_WORD, 1'b1, 32'h0));
    vecs.push_back(mk("ld_sz3",    1'b0, 32'h0,  32'h0, 3'b011,    1'b1, 32'h0));
    vecs.push_back(mk("ld_w_40",   1'b0, 32'h40, 32'h0, SIZE_WORD, 1'b1, 32'h0));
    vecs.push_back(mk("ld_w_10b",  1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 32'hA5A5_55EF));
    vecs.push_back(mk("ld_b_12",   1'b0, 32'h12, 32'h0, SIZE_BYTE, 1'b0, 32'h0000_00A5));
    vecs.push_back(mk("ld_h_12",   1'b0, 32'h12, 32'h0, SIZE_HALF, 1'b0, 32'h0000_A5A5));
    vecs.push_back(mk("ld_w_3c",   1'b0, 32'h3C, 32'h0, SIZE_WORD, 1'b0, 32'h0));
    vecs.push_back(mk("st_w_3c",   1'b1, 32'h3C, 32'h89AB_CDEF, SIZE_WORD, 1'b0, 32'h0));
    vecs.push_back(mk("ld_b_3e",   1'b0, 32'h3E, 32'h0, SIZE_BYTE, 1'b0, 32'h0000_00AB));
    vecs.push_back(mk("ld_h_3e",   1'b0, 32'h3E, 32'h0, SIZE_HALF, 1'b0, 32'h0000_89AB));
    vecs.push_back(mk("ld_w_top",  1'b0, 32'hFFFF_FFFC, 32'h0, SIZE_WORD, 1'b1, 32'h0));
    vecs.push_back(mk("st_b_40",   1'b1, 32'h40, 32'h0000_0077, SIZE_BYTE, 1'b1, 32'h0));
    vecs.push_back(mk("ld_w_0",    1'b0, 32'h0,  32'h0, SIZE_WORD, 1'b0, 32'h0));
    vecs.push_back(mk("ld_sz0",    1'b0, 32'h10, 32'h0, 3'b000,    1'b1, 32'h0));
    vecs.push_back(mk("st_sz7",    1'b1, 32'h10, 32'h0, 3'b111,    1'b1, 32'h0));
    vecs.push_back(mk("ld_w_10c",  1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 32'hA5A5_55EF));
    foreach (vecs[i]) req(vecs[i]);

    @(negedge clk);
    check_rsp("idle", 1'b0, 1'b0, 32'h0);

    // 5: back-to-back store then load of the same word
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h20, 32'h1234_5678, SIZE_WORD);
    @(negedge clk);
    check_rsp("b2b_store", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h20, 32'h0, SIZE_WORD);
    @(negedge clk);
    check_rsp("b2b_load", 1'b1, 1'b0, 32'h1234_5678);
    idle();
    @(negedge clk);
    check_rsp("b2b_after", 1'b0, 1'b0, 32'h0);

    // 6: reset mid-run with a request in flight
    req(mk("t6_st", 1'b1, 32'h30, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 32'h0));
    req(mk("t6_ld", 1'b0, 32'h30, 32'h0, SIZE_WORD, 1'b0, 32'hCAFE_F00D));
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h30, 32'h0, SIZE_WORD);
    reset = 1'b1;
    @(negedge clk);
    check_rsp("t6_abort", 1'b0, 1'b0, 32'h0);
    chk("t6_abort_ready", {31'h0, ready_o}, 32'h0);
    chk("t6_abort_state", {31'h0, dbg_state}, {31'h0, DMEM_INIT});
    reset = 1'b0;
    idle();
    count_init("t6");
    req(mk("t6_ld_30", 1'b0, 32'h30, 32'h0, SIZE_WORD, 1'b0, 32'h0));
    req(mk("t6_ld_10", 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 32'h0));
    req(mk("t6_ld_20", 1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0, 32'h0));

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
